// File: rtl/ram_loader.sv
// Boot loader: packs a byte stream (high byte first) into 16-bit words and
// writes them to consecutive RAM512 addresses from 0, with count and checksum.
module ram_loader #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [AW-1:0] address,
  output logic [DW-1:0] in,
  output logic          load,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count,
  output logic [DW-1:0] checksum
);

  localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

  typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE} state_t;

  state_t      state, nxt;
  logic [AW:0] lim;
  logic [AW:0] count_inc;
  logic        hs;

  assign rx_ready  = (state == HI) || (state == LO);
  assign busy      = (state != IDLE);
  assign hs        = rx_valid && rx_ready;
  assign count_inc = count + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = (len == '0) ? DONE : HI;
      HI:      if (hs) nxt = LO;
      LO:      if (hs) nxt = WRITE;
      WRITE:   nxt = (count_inc == lim) ? DONE : HI;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Datapath registers; load/done are single-cycle strobes aligned with
  // the WRITE and DONE states respectively.
  always_ff @(posedge clk) begin
    if (reset) begin
      lim      <= '0;
      address  <= '0;
      in       <= '0;
      load     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      checksum <= '0;
    end else begin
      load <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          lim      <= (len > DEPTH) ? DEPTH : len;
          count    <= '0;
          address  <= '0;
          checksum <= '0;
          if (len == '0) done <= 1'b1;
        end
        HI: if (hs) in[DW-1:DW-8] <= rx_data;
        LO: if (hs) begin
          in[7:0] <= rx_data;
          load    <= 1'b1;
        end
        WRITE: begin
          count    <= count_inc;
          checksum <= checksum + in;
          // Wraps to 0 only after the final write at the top address.
          address  <= count_inc[AW-1:0];
          if (count_inc == lim) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
